// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: the fill state
// encoding and helpers that split a fetch byte address into tag, set and word index.
package icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FILL  = 2'd3
   } state_t;

   // Instructions are word aligned, so the two lowest byte-address bits never select anything.
   localparam int BYTE_OFFSET_BW = 2;

   function automatic logic [63:0] word_ix_of(input logic [63:0] addr, input int wix_bw);
      return (addr >> BYTE_OFFSET_BW) & ((64'd1 << wix_bw) - 64'd1);
   endfunction

   function automatic logic [63:0] set_of(input logic [63:0] addr, input int wix_bw,
                                          input int set_bw);
      return (addr >> (BYTE_OFFSET_BW + wix_bw)) & ((64'd1 << set_bw) - 64'd1);
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] addr, input int wix_bw,
                                          input int set_bw);
      return addr >> (BYTE_OFFSET_BW + wix_bw + set_bw);
   endfunction

   function automatic int way_bw_of(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Tag and valid storage for every set/way, round-robin victim pointers per set and
// the parallel tag compare that decides hit and hit way for the current lookup.
module icache_tag_store #(
   parameter int SET_BW = 1,
   parameter int WAYS   = 2,
   parameter int WAY_BW = 1,
   parameter int TAG_BW = 26
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SET_BW-1:0] lookup_set,
   input  logic [TAG_BW-1:0] lookup_tag,
   output logic              hit,
   output logic [WAY_BW-1:0] hit_way,
   output logic [WAY_BW-1:0] victim,
   input  logic              alloc_en,
   input  logic [SET_BW-1:0] alloc_set,
   input  logic [WAY_BW-1:0] alloc_way,
   input  logic [TAG_BW-1:0] alloc_tag,
   input  logic              set_valid_en,
   input  logic [SET_BW-1:0] set_valid_set,
   input  logic [WAY_BW-1:0] set_valid_way,
   input  logic              rr_step_en,
   input  logic [SET_BW-1:0] rr_step_set,
   input  logic              clear_all
);

   localparam int SETS = 1 << SET_BW;

   logic [SETS-1:0][WAYS-1:0]   valid_reg;
   logic [SETS-1:0][WAY_BW-1:0] rr_reg;
   logic [WAYS-1:0]             match;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         logic [TAG_BW-1:0] tag_mem [SETS];

         always_ff @(posedge clk) begin
            if (alloc_en && alloc_way == WAY_BW'(gi)) begin
               tag_mem[alloc_set] <= alloc_tag;
            end
         end

         assign match[gi] = valid_reg[lookup_set][gi] && (tag_mem[lookup_set] == lookup_tag);
      end
   endgenerate

   always_comb begin
      hit     = |match;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) begin
            hit_way = WAY_BW'(w);
         end
      end
   end

   assign victim = rr_reg[lookup_set];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         rr_reg    <= '0;
      end else begin
         if (clear_all) begin
            valid_reg <= '0;
         end else begin
            // A reallocated way must stay invalid until its whole line has arrived.
            if (alloc_en) begin
               valid_reg[alloc_set][alloc_way] <= 1'b0;
            end
            if (set_valid_en) begin
               valid_reg[set_valid_set][set_valid_way] <= 1'b1;
            end
         end
         if (rr_step_en) begin
            rr_reg[rr_step_set] <= (rr_reg[rr_step_set] == WAY_BW'(WAYS - 1)) ?
                                   '0 : rr_reg[rr_step_set] + 1'b1;
         end
      end
   end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache in front of a burst RAM: one-cycle
// hits, round-robin refill, critical-word forwarding and fence.i-safe invalidation.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int ADDRESS_BITWIDTH         = 32,
   parameter int DATA_BITWIDTH            = 32,
   parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
   parameter int SET_IX_BITWIDTH          = 1,
   parameter int WAYS                     = 2,
   parameter int RAM_BURST_DATA_COUNT     = 4,
   parameter int RAM_BURST_DATA_BITWIDTH  = 64,
   parameter int RAM_DEPTH_BITWIDTH       = 16
)(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 enable,
   input  logic [ADDRESS_BITWIDTH-1:0]          address,
   input  logic                                 invalidate,
   output logic [DATA_BITWIDTH-1:0]             data,
   output logic                                 data_ready,
   output logic                                 busy,
   output logic [31:0]                          stat_hits,
   output logic [31:0]                          stat_misses,
   output logic                                 br_cmd,
   output logic                                 br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
   output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
   output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
   input  logic                                 br_rd_data_valid,
   input  logic                                 br_busy
);

   localparam int AW            = ADDRESS_BITWIDTH;
   localparam int DW            = DATA_BITWIDTH;
   localparam int RBW           = RAM_BURST_DATA_BITWIDTH;
   localparam int RDW           = RAM_DEPTH_BITWIDTH;
   localparam int WIX           = DATA_IX_IN_LINE_BITWIDTH;
   localparam int SET_BW        = SET_IX_BITWIDTH;
   localparam int COUNT         = RAM_BURST_DATA_COUNT;
   localparam int TAG_BW        = AW - WIX - SET_BW - BYTE_OFFSET_BW;
   localparam int WAY_BW        = way_bw_of(WAYS);
   localparam int DPR           = RBW / DW;
   localparam int BEAT_BW       = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam int BEAT_IX_SHIFT = $clog2(COUNT);
   localparam int LINE_SHIFT    = WIX + BYTE_OFFSET_BW;
   localparam int MEM_BW        = WAY_BW + SET_BW + BEAT_BW;

   generate
      if (COUNT * RBW != DW * (1 << WIX)) begin : g_bad_burst
         $error("icache_assoc: burst count * beat width must equal the line width");
      end
      if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
         $error("icache_assoc: WAYS must be 1, 2 or 4");
      end
   endgenerate

   state_t              state_reg;
   logic [DW-1:0]       data_reg;
   logic                data_ready_reg;
   logic                busy_reg;
   logic                br_cmd_en_reg;
   logic                inval_pending_reg;
   logic [31:0]         hits_reg;
   logic [31:0]         misses_reg;
   logic [RDW-1:0]      br_addr_reg;
   logic [SET_BW-1:0]   set_reg;
   logic [WIX-1:0]      wix_reg;
   logic [WAY_BW-1:0]   way_reg;
   logic [BEAT_BW-1:0]  beat_cnt_reg;

   // Line data, one RAM beat per entry, indexed {way, set, beat}.
   logic [RBW-1:0]      mem [1 << MEM_BW];

   logic [WIX-1:0]      wix_in;
   logic [SET_BW-1:0]   set_in;
   logic [TAG_BW-1:0]   tag_in;
   logic [BEAT_BW-1:0]  hit_beat_ix;
   logic [WIX-1:0]      hit_sub;
   logic [BEAT_BW-1:0]  crit_beat;
   logic [WIX-1:0]      crit_sub;
   logic [RBW-1:0]      hit_line;
   logic [AW-1:0]       line_shifted;
   logic [RDW-1:0]      br_addr_next;

   logic                hit;
   logic [WAY_BW-1:0]   hit_way;
   logic [WAY_BW-1:0]   victim;
   logic                lookup_fire;
   logic                miss_fire;
   logic                beat_fire;
   logic                last_beat;
   logic                inval_any;
   logic                clear_all;
   logic                commit_en;

   assign wix_in = WIX'(word_ix_of(64'(address), WIX));
   assign set_in = SET_BW'(set_of(64'(address), WIX, SET_BW));
   assign tag_in = TAG_BW'(tag_of(64'(address), WIX, SET_BW));

   assign hit_beat_ix = BEAT_BW'(wix_in / WIX'(DPR));
   assign hit_sub     = wix_in % WIX'(DPR);
   assign crit_beat   = BEAT_BW'(wix_reg / WIX'(DPR));
   assign crit_sub    = wix_reg % WIX'(DPR);
   assign hit_line    = mem[{hit_way, set_in, hit_beat_ix}];

   // Beat-granular RAM address of the line start: beat-in-line bits forced to zero.
   assign line_shifted = (address >> LINE_SHIFT) << BEAT_IX_SHIFT;
   assign br_addr_next = RDW'(line_shifted);

   // An invalidate in IDLE wins over a fetch presented in the same cycle.
   assign lookup_fire = (state_reg == ST_IDLE) && enable && !invalidate;
   assign miss_fire   = lookup_fire && !hit;
   assign beat_fire   = ((state_reg == ST_WAIT) || (state_reg == ST_FILL)) && br_rd_data_valid;
   assign last_beat   = beat_fire && (beat_cnt_reg == BEAT_BW'(COUNT - 1));
   assign inval_any   = inval_pending_reg || invalidate;
   assign clear_all   = ((state_reg == ST_IDLE) && invalidate) || (last_beat && inval_any);
   assign commit_en   = last_beat && !inval_any;

   icache_tag_store #(
      .SET_BW (SET_BW),
      .WAYS   (WAYS),
      .WAY_BW (WAY_BW),
      .TAG_BW (TAG_BW)
   ) u_tag_store (
      .clk           (clk),
      .rst_n         (rst_n),
      .lookup_set    (set_in),
      .lookup_tag    (tag_in),
      .hit           (hit),
      .hit_way       (hit_way),
      .victim        (victim),
      .alloc_en      (miss_fire),
      .alloc_set     (set_in),
      .alloc_way     (victim),
      .alloc_tag     (tag_in),
      .set_valid_en  (commit_en),
      .set_valid_set (set_reg),
      .set_valid_way (way_reg),
      .rr_step_en    (last_beat),
      .rr_step_set   (set_reg),
      .clear_all     (clear_all)
   );

   always_ff @(posedge clk) begin
      if (beat_fire) begin
         mem[{way_reg, set_reg, beat_cnt_reg}] <= br_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= ST_IDLE;
         data_reg          <= '0;
         data_ready_reg    <= 1'b0;
         busy_reg          <= 1'b0;
         br_cmd_en_reg     <= 1'b0;
         inval_pending_reg <= 1'b0;
         hits_reg          <= '0;
         misses_reg        <= '0;
         br_addr_reg       <= '0;
         set_reg           <= '0;
         wix_reg           <= '0;
         way_reg           <= '0;
         beat_cnt_reg      <= '0;
      end else begin
         data_ready_reg <= 1'b0;
         br_cmd_en_reg  <= 1'b0;
         if (invalidate && state_reg != ST_IDLE) begin
            inval_pending_reg <= 1'b1;
         end
         case (state_reg)
            ST_IDLE: begin
               if (lookup_fire && hit) begin
                  data_reg       <= hit_line[int'(hit_sub) * DW +: DW];
                  data_ready_reg <= 1'b1;
                  hits_reg       <= hits_reg + 32'd1;
               end else if (miss_fire) begin
                  set_reg      <= set_in;
                  wix_reg      <= wix_in;
                  way_reg      <= victim;
                  br_addr_reg  <= br_addr_next;
                  beat_cnt_reg <= '0;
                  busy_reg     <= 1'b1;
                  misses_reg   <= misses_reg + 32'd1;
                  state_reg    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!br_busy) begin
                  br_cmd_en_reg <= 1'b1;
                  state_reg     <= ST_WAIT;
               end
            end
            ST_WAIT, ST_FILL: begin
               if (br_rd_data_valid) begin
                  if (beat_cnt_reg == crit_beat) begin
                     data_reg       <= br_rd_data[int'(crit_sub) * DW +: DW];
                     data_ready_reg <= 1'b1;
                  end
                  if (last_beat) begin
                     beat_cnt_reg      <= '0;
                     busy_reg          <= 1'b0;
                     inval_pending_reg <= 1'b0;
                     state_reg         <= ST_IDLE;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                     state_reg    <= ST_FILL;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign data         = data_reg;
   assign data_ready   = data_ready_reg;
   assign busy         = busy_reg;
   assign stat_hits    = hits_reg;
   assign stat_misses  = misses_reg;
   assign br_cmd       = 1'b0;
   assign br_cmd_en    = br_cmd_en_reg;
   assign br_addr      = br_addr_reg;
   assign br_wr_data   = '0;
   assign br_data_mask = '0;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed and randomized fetch sequences for icache_assoc, checked against a
// line-level reference model of the cache contents and a synthetic RAM image.
module tb_icache_assoc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] address = '0;
   logic        invalidate = 1'b0;
   logic [31:0] data;
   logic        data_ready;
   logic        busy;
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
   logic        br_cmd;
   logic        br_cmd_en;
   logic [15:0] br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;
   logic [63:0] br_rd_data = '0;
   logic        br_rd_data_valid = 1'b0;
   logic        br_busy = 1'b0;

   icache_assoc dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .address          (address),
      .invalidate       (invalidate),
      .data             (data),
      .data_ready       (data_ready),
      .busy             (busy),
      .stat_hits        (stat_hits),
      .stat_misses      (stat_misses),
      .br_cmd           (br_cmd),
      .br_cmd_en        (br_cmd_en),
      .br_addr          (br_addr),
      .br_wr_data       (br_wr_data),
      .br_data_mask     (br_data_mask),
      .br_rd_data       (br_rd_data),
      .br_rd_data_valid (br_rd_data_valid),
      .br_busy          (br_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: 2 sets x 2 ways, round-robin victim per set.
   bit          m_valid [2][2];
   logic [25:0] m_tag   [2][2];
   int          m_rr    [2];
   bit          m_pend;
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   function automatic logic [31:0] wfn(input logic [31:0] a);
      return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A3C_0F00;
   endfunction

   function automatic logic [63:0] beat(input logic [31:0] line, input int k);
      return {wfn(line + 32'(k * 8 + 4)), wfn(line + 32'(k * 8))};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
      end
      m_pend   = 1'b0;
      m_hits   = '0;
      m_misses = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, data, 0);
      check({tag, "_ready"}, data_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_hits"}, stat_hits, 0);
      check({tag, "_misses"}, stat_misses, 0);
      check({tag, "_cmd_en"}, br_cmd_en, 0);
      check({tag, "_br_addr"}, br_addr, 0);
   endtask

   task automatic noise_drive(input bit noise);
      if (noise) begin
         enable  = 1'($urandom_range(0, 1));
         address = $urandom;
      end
      br_rd_data = {$urandom, $urandom};
   endtask

   // One fetch; for a miss the bench also plays the RAM. inv_k / rst_k select the
   // beat on which an invalidate pulse is given / after which reset is asserted.
   task automatic fetch(input logic [31:0] a, input int bb, input int inv_k,
                        input int rst_k, input bit noise);
      int          set;
      int          way;
      int          crit;
      int          n;
      int          gaps;
      bit          hit;
      logic [25:0] tg;
      logic [31:0] line;
      set  = int'(a[5]);
      tg   = a[31:6];
      crit = int'(a[4:2]) / 2;
      line = a & ~32'h1F;
      hit  = 1'b0;
      for (int w = 0; w < 2; w++) if (m_valid[set][w] && m_tag[set][w] == tg) hit = 1'b1;
      $display("fetch addr=%08h expect_hit=%0d br_busy_cycles=%0d", a, hit, bb);

      enable  = 1'b1;
      address = a;
      br_busy = (bb > 0);
      tick();
      enable = 1'b0;
      if (hit) begin
         m_hits++;
         check("hit_ready", data_ready, 1);
         check("hit_data", data, wfn(a & ~32'h3));
         check("hit_busy", busy, 0);
         check("hit_cmd_en", br_cmd_en, 0);
         check("hit_count", stat_hits, m_hits);
         return;
      end

      m_misses++;
      way = m_rr[set];
      m_valid[set][way] = 1'b0;
      check("miss_busy", busy, 1);
      check("miss_ready", data_ready, 0);
      check("miss_count", stat_misses, m_misses);

      n = 0;
      while (n < 40) begin
         if (n >= bb) br_busy = 1'b0;
         noise_drive(noise);
         tick();
         n++;
         if (br_cmd_en) break;
      end
      br_busy = 1'b0;
      check("cmd_en_seen", br_cmd_en, 1);
      check("cmd_delay", n, bb + 1);
      check("br_addr", br_addr, (line >> 3) & 32'hFFFF);
      check("br_cmd", br_cmd, 0);
      if (!br_cmd_en) begin
         enable = 1'b0;
         return;
      end

      for (int k = 0; k < 4; k++) begin
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            noise_drive(noise);
            tick();
            check("gap_ready", data_ready, 0);
            check("gap_busy", busy, 1);
            check("gap_cmd_en", br_cmd_en, 0);
         end
         noise_drive(noise);
         br_rd_data       = beat(line, k);
         br_rd_data_valid = 1'b1;
         if (k == inv_k) begin
            invalidate = 1'b1;
            m_pend     = 1'b1;
         end
         tick();
         br_rd_data_valid = 1'b0;
         invalidate       = 1'b0;
         check("beat_cmd_en", br_cmd_en, 0);
         check("beat_ready", data_ready, (k == crit) ? 1 : 0);
         if (k == crit) check("crit_data", data, wfn(a & ~32'h3));
         check("beat_busy", busy, (k != 3) ? 1 : 0);
         if (k == rst_k) begin
            enable = 1'b0;
            rst_n  = 1'b0;
            #1;
            model_reset();
            check_reset_outputs("midfill_rst");
            tick();
            rst_n = 1'b1;
            for (int s = k + 1; s < 4; s++) begin
               br_rd_data       = beat(line, s);
               br_rd_data_valid = 1'b1;
               tick();
               br_rd_data_valid = 1'b0;
               check("stray_ready", data_ready, 0);
               check("stray_busy", busy, 0);
               check("stray_misses", stat_misses, 0);
            end
            return;
         end
      end
      enable = 1'b0;

      if (m_pend) begin
         for (int s = 0; s < 2; s++) for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
      end else begin
         m_valid[set][way] = 1'b1;
         m_tag[set][way]   = tg;
      end
      m_rr[set] = (m_rr[set] + 1) % 2;
      m_pend    = 1'b0;
      check("fill_hits", stat_hits, m_hits);
      check("fill_misses", stat_misses, m_misses);
   endtask

   task automatic inval_idle(input logic [31:0] a);
      $display("invalidate with fetch addr=%08h", a);
      enable     = 1'b1;
      address    = a;
      invalidate = 1'b1;
      tick();
      enable     = 1'b0;
      invalidate = 1'b0;
      check("inv_ready", data_ready, 0);
      check("inv_busy", busy, 0);
      check("inv_hits", stat_hits, m_hits);
      check("inv_misses", stat_misses, m_misses);
      for (int s = 0; s < 2; s++) for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Cold miss with critical word in beat 2, then a hit in the same line.
      fetch(32'h14, 0, -1, -1, 1'b0);
      fetch(32'h10, 0, -1, -1, 1'b0);
      check("first_hit_count", stat_hits, 1);

      // Second way of set 0, both lines resident, then round-robin eviction.
      fetch(32'h40, 0, -1, -1, 1'b0);
      fetch(32'h00, 0, -1, -1, 1'b0);
      fetch(32'h44, 0, -1, -1, 1'b0);
      fetch(32'h80, 0, -1, -1, 1'b0);
      fetch(32'h5C, 0, -1, -1, 1'b0);
      fetch(32'h00, 0, -1, -1, 1'b0);

      // RAM busy during command issue, with ignored fetch requests during the fill.
      fetch(32'h28, 5, -1, -1, 1'b1);
      fetch(32'h2C, 0, -1, -1, 1'b0);

      // Invalidate together with a fetch in IDLE drops the fetch.
      inval_idle(32'h28);
      fetch(32'h28, 0, -1, -1, 1'b0);

      // Invalidate during a fill: critical word still arrives, nothing stays valid.
      fetch(32'h00, 0, 1, -1, 1'b0);
      fetch(32'h04, 0, -1, -1, 1'b0);
      fetch(32'h28, 0, -1, -1, 1'b0);

      // Reset between beats 1 and 2.
      fetch(32'h100, 0, -1, 1, 1'b0);
      fetch(32'h00, 0, -1, -1, 1'b0);
      check("post_reset_misses", stat_misses, 1);

      // Randomized traffic over a small pool of lines to mix hits, misses and evictions.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra;
         ra = (32'($urandom_range(0, 5)) << 5) | (32'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 14) == 0) begin
            inval_idle(ra);
         end else begin
            fetch(ra, $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1, -1, 1'b1);
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
